// File: rtl/sram_like_arbiter.sv
// N-channel sram-like arbiter: fixed-priority or round-robin grant onto one slave port,
// with an in-order channel-ID FIFO routing data_ok back to the issuing master.
module sram_like_arbiter #(
    parameter int N_CH       = 2,
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int RR_MODE    = 0,
    parameter int OUTS_DEPTH = 2
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [N_CH-1:0]                m_req,
    input  logic [N_CH-1:0]                m_wr,
    input  logic [2*N_CH-1:0]              m_size,
    input  logic [ADDR_W*N_CH-1:0]         m_addr,
    input  logic [DATA_W*N_CH-1:0]         m_wdata,
    output logic [N_CH-1:0]                m_addr_ok,
    output logic [N_CH-1:0]                m_data_ok,
    output logic [DATA_W-1:0]              m_rdata,
    output logic                           s_req,
    output logic                           s_wr,
    output logic [1:0]                     s_size,
    output logic [ADDR_W-1:0]              s_addr,
    output logic [DATA_W-1:0]              s_wdata,
    input  logic                           s_addr_ok,
    input  logic                           s_data_ok,
    input  logic [DATA_W-1:0]              s_rdata,
    output logic [$clog2(OUTS_DEPTH):0]    outstanding,
    output logic                           proto_err
);
    localparam int IW = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int PW = (OUTS_DEPTH > 1) ? $clog2(OUTS_DEPTH) : 1;
    localparam int CW = $clog2(OUTS_DEPTH) + 1;

    logic          lock_vld;
    logic [IW-1:0] lock_idx;
    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] fifo [OUTS_DEPTH];
    logic [PW-1:0] head, tail;
    logic [CW-1:0] count;

    logic          sel_vld;
    logic [IW-1:0] sel_idx;
    logic          found;
    logic          push, pop;

    // A held lock overrides the full check; a lock can only form while not full.
    always_comb begin
        sel_vld = 1'b0;
        sel_idx = '0;
        found   = 1'b0;
        if (lock_vld) begin
            sel_vld = 1'b1;
            sel_idx = lock_idx;
        end else if (count < CW'(OUTS_DEPTH) && |m_req) begin
            sel_vld = 1'b1;
            if (RR_MODE == 0) begin
                for (int unsigned i = N_CH; i > 0; i--) begin
                    if (m_req[i-1]) sel_idx = IW'(i - 1);
                end
            end else begin
                for (int unsigned k = 0; k < N_CH; k++) begin
                    if (!found && m_req[(32'(rr_ptr) + k) % N_CH]) begin
                        found   = 1'b1;
                        sel_idx = IW'((32'(rr_ptr) + k) % N_CH);
                    end
                end
            end
        end
    end

    always_comb begin
        s_req   = 1'b0;
        s_wr    = 1'b0;
        s_size  = '0;
        s_addr  = '0;
        s_wdata = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (sel_vld && sel_idx == IW'(i)) begin
                s_req   = m_req[i];
                s_wr    = m_wr[i];
                s_size  = m_size[2*i +: 2];
                s_addr  = m_addr[ADDR_W*i +: ADDR_W];
                s_wdata = m_wdata[DATA_W*i +: DATA_W];
            end
        end
    end

    assign push        = s_req & s_addr_ok;
    assign pop         = s_data_ok & (count != '0);
    assign m_addr_ok   = push ? (N_CH'(1) << sel_idx) : '0;
    assign m_data_ok   = pop ? (N_CH'(1) << fifo[head]) : '0;
    assign m_rdata     = s_rdata;
    assign outstanding = count;

    always_ff @(posedge clk) begin
        if (rst) begin
            lock_vld  <= 1'b0;
            lock_idx  <= '0;
            rr_ptr    <= '0;
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            proto_err <= 1'b0;
        end else begin
            if (push) begin
                lock_vld <= 1'b0;
            end else if (s_req) begin
                lock_vld <= 1'b1;
                lock_idx <= sel_idx;
            end else begin
                lock_vld <= 1'b0;
            end
            if (push && RR_MODE != 0)
                rr_ptr <= (sel_idx == IW'(N_CH - 1)) ? '0 : sel_idx + IW'(1);
            if (push)
                tail <= (tail == PW'(OUTS_DEPTH - 1)) ? '0 : tail + PW'(1);
            if (pop)
                head <= (head == PW'(OUTS_DEPTH - 1)) ? '0 : head + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (s_data_ok && count == '0)
                proto_err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo[tail] <= sel_idx;
    end

endmodule

// File: doc/sram_like_arbiter.md
Name: sram_like_arbiter

Overview:
- Parametrised N-channel arbiter merging several sram-like masters onto one sram-like slave port. Generalises the fixed instruction/data pair the core drives into the AXI bridge.
- Supports fixed-priority or round-robin arbitration and up to OUTS_DEPTH address-accepted-but-data-pending transactions.
- Returns data in order using an internal channel-ID FIFO.
- Sits between the core (instr/data sram-like ports) and the sram-like-to-AXI converter.

Parameters:
N_CH, 2, number of master channels (2..8)
ADDR_W, 32, address width
DATA_W, 32, data width
RR_MODE, 0, 0 = fixed priority (channel 0 highest), 1 = round-robin
OUTS_DEPTH, 2, max outstanding transactions (power of 2, 1..8)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous active-high reset
m_req  in  N_CH  per-channel request
m_wr  in  N_CH  per-channel write (1) / read (0)
m_size  in  2*N_CH  per-channel size, channel i at [2i+1:2i]
m_addr  in  ADDR_W*N_CH  per-channel address, channel i at slice i
m_wdata  in  DATA_W*N_CH  per-channel write data, channel i at slice i
m_addr_ok  out  N_CH  address accepted, one-hot or zero
m_data_ok  out  N_CH  data complete, one-hot or zero
m_rdata  out  DATA_W  read data, broadcast to all channels
s_req  out  1  slave request
s_wr  out  1  slave write
s_size  out  2  slave size
s_addr  out  ADDR_W  slave address
s_wdata  out  DATA_W  slave write data
s_addr_ok  in  1  slave address accepted
s_data_ok  in  1  slave data complete
s_rdata  in  DATA_W  slave read data
outstanding  out  $clog2(OUTS_DEPTH)+1  current FIFO occupancy
proto_err  out  1  sticky: s_data_ok received with FIFO empty

Behaviour:
- State:
  - lock_vld/lock_idx: a grant is held while waiting for s_addr_ok.
  - rr_ptr: round-robin start index.
  - ID FIFO: OUTS_DEPTH entries of channel index, with head/tail/count.
- Reset (rst=1 at edge): lock_vld=0, rr_ptr=0, FIFO emptied (count=0), proto_err=0. Reset mid-transaction drops all pending IDs; the slave is required to be reset in the same cycle.
- Grant selection (combinational):
  - If lock_vld: selected channel is lock_idx.
  - Else, if count < OUTS_DEPTH and any m_req bit is set: winner = lowest requesting index (RR_MODE=0), or first requesting index scanning rr_ptr, rr_ptr+1, … modulo N_CH (RR_MODE=1).
  - Otherwise no selection and s_req=0.
- Slave drive:
  - s_req = m_req[sel] when a selection exists.
  - s_wr, s_size, s_addr, s_wdata = sel's fields. They are zero when no selection exists.
  - Zero added latency: a request can be issued in the same cycle m_req rises.
- Address handshake:
  - When s_req & s_addr_ok: m_addr_ok[sel]=1 the same cycle; sel is pushed to the FIFO tail at the edge; lock_vld cleared; if RR_MODE=1, rr_ptr <= (sel+1) mod N_CH.
  - When s_req & ~s_addr_ok: lock_vld<=1 and lock_idx<=sel. The grant cannot be preempted by higher-priority requests until accepted.
- Master rule: a master holds m_req and its fields stable until its m_addr_ok. If the locked master drops m_req, s_req drops and the lock is released at the next edge.
- Data handshake:
  - When s_data_ok and count>0: m_data_ok[FIFO head]=1 and m_rdata=s_rdata the same cycle; head is popped at the edge.
  - m_rdata = s_rdata at all times, and is valid only with m_data_ok.
- Simultaneous push and pop: count unchanged, both pointers advance.
- Full: when count==OUTS_DEPTH, no new grant, even if a pop occurs in the same cycle (no bypass). An existing lock cannot occur while full.
- Empty-FIFO s_data_ok: ignored (no m_data_ok), proto_err<=1 until reset.
- Pointers wrap modulo OUTS_DEPTH. count ranges 0..OUTS_DEPTH.
- Outputs after reset with all inputs 0: all outputs 0.

Test Plan:
1. RR_MODE=0, N_CH=2, both m_req=1 at cycle 0 with s_addr_ok=1 → ch0 granted cycle 0 (m_addr_ok=2'b01); ch1 granted cycle 1 (2'b10). Two later s_data_ok pulses with s_rdata=0x11111111, 0x22222222 → m_data_ok=01 then 10 with matching m_rdata.
2. RR_MODE=1, N_CH=4, all four m_req held, s_addr_ok always 1, s_data_ok every cycle → grant order 0,1,2,3,0. outstanding never exceeds 1.
3. Lock: ch1 requests alone, s_addr_ok=0 for 3 cycles, ch0 raises req at cycle 1 → s_addr stays ch1's 0xBFC00004 until s_addr_ok. m_addr_ok=2'b10, then ch0 is granted next cycle.
4. Full: OUTS_DEPTH=2, two addresses accepted with no data_ok → outstanding=2, third request sees s_req=0. s_data_ok pulse → head channel acked; new grant the following cycle, not the same cycle.
5. Push+pop same cycle with outstanding=1 → outstanding stays 1 and data_ok goes to the older ID.
6. s_data_ok with outstanding=0 → no m_data_ok, proto_err=1 sticky. Assert rst mid-traffic → outstanding=0, proto_err=0, s_req=0 next cycle with m_req low.
